// File: rtl/usb_pkg.sv
// Shared USB host-side types: sequencer states, response outcomes, PID codes.
package usb_pkg;

  // Host transaction sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StTx,
    StRxWait,
    StRxEop,
    StTxAck,
    StDone
  } txn_state_e;

  // What the response PID told us, resolved once EOP arrives.
  typedef enum logic [1:0] {
    OC_GOOD,
    OC_BAD,
    OC_CRC
  } outcome_e;

  // PID codes as seen by the receive decode FSM (low nibble of the PID byte).
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // Counter width for a timeout of cyc cycles; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned cyc);
    return (cyc > 2) ? $clog2(cyc) : 1;
  endfunction

  // Classify a response PID. OUT only accepts ACK; IN only accepts DATA0,
  // which still needs the CRC verdict at EOP.
  function automatic outcome_e classify_pid(input logic is_in, input logic ack,
                                            input logic nak, input logic data0);
    outcome_e oc;
    oc = OC_BAD;
    if (is_in) begin
      if (data0) oc = OC_CRC;
    end else begin
      if (ack) oc = OC_GOOD;
    end
    if (!ack && !nak && !data0) oc = OC_BAD;
    return oc;
  endfunction

endpackage

// File: rtl/usb_timeout_timer.sv
// Saturating cycle timer: clear restarts it, enable advances it, expired flags
// the last allowed cycle (count == TIMEOUT_CYC-1).
module usb_timeout_timer
  import usb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned TimerW = timer_width(TIMEOUT_CYC);
  localparam logic [TimerW-1:0] LastCount = TimerW'(TIMEOUT_CYC - 1);

  logic [TimerW-1:0] count_q, count_d;

  // Clear wins over enable; the count parks at LastCount instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LastCount)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LastCount);

endmodule

// File: rtl/usb_rx_txn_sequencer.sv
// Host transaction sequencer: sends the token/data packet, arms the receiver,
// resolves the response (with timeout), ACKs good IN data and retries failed
// attempts up to MAX_RETRY before reporting one done/success result.
module usb_rx_txn_sequencer
  import usb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned MAX_RETRY   = 8,
  parameter int unsigned RW          = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          txn_start,
  input  logic          txn_is_in,
  output logic          txn_ready,
  output logic          tx_start,
  output logic          send_ack,
  input  logic          tx_done,
  output logic          rec_start,
  input  logic          ACK_rec,
  input  logic          NAK_rec,
  input  logic          DATA0_rec,
  input  logic          rec_failed,
  input  logic          rec_eop,
  input  logic          crc_ok,
  output logic          txn_done,
  output logic          txn_success,
  output logic [RW-1:0] txn_retries
);

  localparam logic [RW-1:0] MaxRetry = RW'(MAX_RETRY);

  txn_state_e    state_q, state_d;
  outcome_e      outcome_q, outcome_d;
  logic          is_in_q, is_in_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          success_q, success_d;
  logic [RW-1:0] retries_out_q, retries_out_d;

  logic fire_tx, fire_ack, fire_rec;
  logic retry_req, finish_ok;
  logic pid_seen;
  logic timer_clear, timer_en, timer_expired;

  assign pid_seen = ACK_rec | NAK_rec | DATA0_rec;
  assign timer_en = (state_q == StRxWait) || (state_q == StRxEop);

  usb_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // State and transaction context registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      outcome_q     <= OC_BAD;
      is_in_q       <= 1'b0;
      retry_q       <= '0;
      success_q     <= 1'b0;
      retries_out_q <= '0;
    end else begin
      state_q       <= state_d;
      outcome_q     <= outcome_d;
      is_in_q       <= is_in_d;
      retry_q       <= retry_d;
      success_q     <= success_d;
      retries_out_q <= retries_out_d;
    end
  end

  // Next-state logic; per-state decisions collapse into finish_ok / retry_req
  // so the retry-or-give-up rule lives in one place.
  always_comb begin
    state_d       = state_q;
    outcome_d     = outcome_q;
    is_in_d       = is_in_q;
    retry_d       = retry_q;
    success_d     = success_q;
    retries_out_d = retries_out_q;
    fire_tx       = 1'b0;
    fire_ack      = 1'b0;
    fire_rec      = 1'b0;
    timer_clear   = 1'b0;
    retry_req     = 1'b0;
    finish_ok     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (txn_start) begin
          is_in_d   = txn_is_in;
          retry_d   = '0;
          success_d = 1'b0;
          fire_tx   = 1'b1;
          state_d   = StTx;
        end
      end
      StTx: begin
        if (tx_done) begin
          fire_rec    = 1'b1;
          timer_clear = 1'b1;
          state_d     = StRxWait;
        end
      end
      StRxWait: begin
        // A decoder failure outranks any PID; a PID outranks the timeout.
        if (rec_failed) begin
          retry_req = 1'b1;
        end else if (pid_seen) begin
          outcome_d   = classify_pid(is_in_q, ACK_rec, NAK_rec, DATA0_rec);
          timer_clear = 1'b1;
          state_d     = StRxEop;
        end else if (timer_expired) begin
          retry_req = 1'b1;
        end
      end
      StRxEop: begin
        if (rec_eop) begin
          if (outcome_q == OC_GOOD) begin
            finish_ok = 1'b1;
          end else if ((outcome_q == OC_CRC) && crc_ok) begin
            fire_ack = 1'b1;
            state_d  = StTxAck;
          end else begin
            retry_req = 1'b1;
          end
        end else if (timer_expired) begin
          retry_req = 1'b1;
        end
      end
      StTxAck: begin
        if (tx_done) finish_ok = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (finish_ok) begin
      state_d       = StDone;
      success_d     = 1'b1;
      retries_out_d = retry_q;
    end

    if (retry_req) begin
      if (retry_q == MaxRetry) begin
        state_d       = StDone;
        success_d     = 1'b0;
        retries_out_d = retry_q;
      end else begin
        retry_d = retry_q + 1'b1;
        fire_tx = 1'b1;
        state_d = StTx;
      end
    end
  end

  // Outputs; strobes are suppressed during reset so no pulse leaks out.
  always_comb begin
    txn_ready   = (state_q == StIdle);
    tx_start    = fire_tx & ~reset;
    send_ack    = fire_ack & ~reset;
    rec_start   = fire_rec & ~reset;
    txn_done    = (state_q == StDone) & ~reset;
    txn_success = success_q;
    txn_retries = retries_out_q;
  end

endmodule

// File: tb/tb_usb_rx_txn_sequencer.sv
// Bench for usb_rx_txn_sequencer: plays encoder and decoder, checks each
// transaction against table expectations or a per-attempt outcome model.
module tb_usb_rx_txn_sequencer;

  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 2;
  localparam int NATT      = MAX_RETRY + 1;

  typedef enum logic [3:0] {
    RespAck, RespNak, RespD0Good, RespD0Bad, RespFail, RespFailAck,
    RespSilent, RespNoEop, RespLateAck
  } resp_e;

  typedef struct {
    logic  is_in;
    resp_e r0;
    resp_e r1;
    resp_e r2;
    logic  succ;
    int    rtr;
    int    ntx;
    int    nack;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       txn_start = 1'b0;
  logic       txn_is_in = 1'b0;
  logic       txn_ready, tx_start, send_ack, rec_start, txn_done, txn_success;
  logic       tx_done = 1'b0;
  logic       ack_rec = 1'b0, nak_rec = 1'b0, data0_rec = 1'b0;
  logic       rec_failed = 1'b0, rec_eop = 1'b0, crc_ok = 1'b0;
  logic [3:0] txn_retries;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rec_cyc  = 0;
  int cnt_tx = 0, cnt_rec = 0, cnt_ack = 0, cnt_done = 0;
  logic prev_succ = 1'b0;

  usb_rx_txn_sequencer #(
    .TIMEOUT_CYC(TIMEOUT),
    .MAX_RETRY  (MAX_RETRY),
    .RW         (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .txn_start  (txn_start),
    .txn_is_in  (txn_is_in),
    .txn_ready  (txn_ready),
    .tx_start   (tx_start),
    .send_ack   (send_ack),
    .tx_done    (tx_done),
    .rec_start  (rec_start),
    .ACK_rec    (ack_rec),
    .NAK_rec    (nak_rec),
    .DATA0_rec  (data0_rec),
    .rec_failed (rec_failed),
    .rec_eop    (rec_eop),
    .crc_ok     (crc_ok),
    .txn_done   (txn_done),
    .txn_success(txn_success),
    .txn_retries(txn_retries)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (tx_start)  cnt_tx   <= cnt_tx + 1;
    if (rec_start) cnt_rec  <= cnt_rec + 1;
    if (send_ack)  cnt_ack  <= cnt_ack + 1;
    if (txn_done)  cnt_done <= cnt_done + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge and drop all one-cycle pulses.
  task automatic step();
    @(posedge clock);
    #1;
    txn_start  = 1'b0;
    tx_done    = 1'b0;
    ack_rec    = 1'b0;
    nak_rec    = 1'b0;
    data0_rec  = 1'b0;
    rec_failed = 1'b0;
    rec_eop    = 1'b0;
    crc_ok     = 1'b0;
  endtask

  // 0 = nothing within budget, 1 = tx_start seen, 2 = txn_done seen.
  task automatic wait_evt(output int kind);
    kind = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (txn_done) begin
        kind = 2;
        break;
      end
      if (tx_start) begin
        kind = 1;
        break;
      end
      step();
    end
  endtask

  // Outcome model: the first attempt whose response is acceptable for the
  // direction wins; otherwise every allowed attempt is spent.
  function automatic void model(input logic is_in, input resp_e r0, input resp_e r1,
                                input resp_e r2, output logic s, output int rt,
                                output int ntx, output int nack);
    resp_e rs[NATT];
    logic  good;
    rs   = '{r0, r1, r2};
    s    = 1'b0;
    rt   = MAX_RETRY;
    ntx  = MAX_RETRY + 1;
    nack = 0;
    for (int a = 0; a < NATT; a++) begin
      good = is_in ? (rs[a] == RespD0Good) : (rs[a] == RespAck || rs[a] == RespLateAck);
      if (good) begin
        s    = 1'b1;
        rt   = a;
        ntx  = a + 1;
        nack = is_in ? 1 : 0;
        break;
      end
    end
  endfunction

  function automatic resp_e rand_resp();
    logic [3:0] v;
    v = 4'($urandom_range(0, 8));
    return resp_e'(v);
  endfunction

  // Encoder/decoder behaviour for one attempt, starting in the tx_start cycle.
  task automatic respond(input logic is_in, input resp_e r);
    int d;
    step();
    d = $urandom_range(0, 3);
    repeat (d) step();
    tx_done = 1'b1;
    rec_cyc = cyc;
    step();
    d = (r == RespLateAck) ? TIMEOUT - 1 : $urandom_range(0, 3);
    repeat (d) step();
    case (r)
      RespAck, RespLateAck:            ack_rec = 1'b1;
      RespNak:                         nak_rec = 1'b1;
      RespD0Good, RespD0Bad, RespNoEop: data0_rec = 1'b1;
      RespFail:                        rec_failed = 1'b1;
      RespFailAck: begin
        rec_failed = 1'b1;
        ack_rec    = 1'b1;
      end
      default: ;
    endcase
    if (r inside {RespAck, RespNak, RespD0Good, RespD0Bad, RespLateAck}) begin
      step();
      d = $urandom_range(0, 3);
      repeat (d) step();
      rec_eop = 1'b1;
      crc_ok  = (r == RespD0Good);
      if (is_in && r == RespD0Good) begin
        step();
        d = $urandom_range(0, 3);
        repeat (d) step();
        tx_done = 1'b1;
      end
    end
  endtask

  task automatic run_txn(input logic is_in, input resp_e r0, input resp_e r1, input resp_e r2,
                         input logic e_succ, input int e_rtr, input int e_tx, input int e_ack);
    resp_e rs[NATT];
    int    kind, att;
    int    tx0, rec0, ack0, done0;
    int    a_succ, a_rtr;
    rs = '{r0, r1, r2};
    chk("ready_in_idle", int'(txn_ready), 1);
    chk("success_held", int'(txn_success), int'(prev_succ));
    tx0   = cnt_tx;
    rec0  = cnt_rec;
    ack0  = cnt_ack;
    done0 = cnt_done;
    txn_start = 1'b1;
    txn_is_in = is_in;
    wait_evt(kind);
    chk("start_accept", kind, 1);
    att = 0;
    while (kind == 1 && att < NATT) begin
      respond(is_in, rs[att]);
      att++;
      wait_evt(kind);
      if (rs[att-1] == RespSilent && kind != 0)
        chk("rx_wait_len", cyc - rec_cyc - ((kind == 2) ? 1 : 0), TIMEOUT);
    end
    a_succ = int'(txn_success);
    a_rtr  = int'(txn_retries);
    chk("done_seen", kind, 2);
    step();
    chk("success", a_succ, int'(e_succ));
    chk("retries", a_rtr, e_rtr);
    chk("tx_start_cnt", cnt_tx - tx0, e_tx);
    chk("rec_start_cnt", cnt_rec - rec0, e_tx);
    chk("send_ack_cnt", cnt_ack - ack0, e_ack);
    chk("done_cnt", cnt_done - done0, 1);
    prev_succ = e_succ;
    if (kind != 2) begin
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      prev_succ = 1'b0;
    end
  endtask

  vec_t vecs[10];

  initial begin
    logic  s_m;
    int    rt_m, tx_m, ak_m;
    logic  in_r;
    resp_e q0, q1, q2;
    int    kind;

    vecs[0] = '{1'b0, RespAck,     RespAck,    RespAck,    1'b1, 0, 1, 0};
    vecs[1] = '{1'b0, RespNak,     RespNak,    RespAck,    1'b1, 2, 3, 0};
    vecs[2] = '{1'b1, RespD0Good,  RespAck,    RespAck,    1'b1, 0, 1, 1};
    vecs[3] = '{1'b1, RespD0Bad,   RespD0Good, RespAck,    1'b1, 1, 2, 1};
    vecs[4] = '{1'b0, RespSilent,  RespSilent, RespSilent, 1'b0, 2, 3, 0};
    vecs[5] = '{1'b0, RespFailAck, RespAck,    RespAck,    1'b1, 1, 2, 0};
    vecs[6] = '{1'b0, RespLateAck, RespAck,    RespAck,    1'b1, 0, 1, 0};
    vecs[7] = '{1'b1, RespAck,     RespNoEop,  RespD0Good, 1'b1, 2, 3, 1};
    vecs[8] = '{1'b0, RespNak,     RespNak,    RespNak,    1'b0, 2, 3, 0};
    vecs[9] = '{1'b1, RespFail,    RespLateAck, RespNak,   1'b0, 2, 3, 0};

    // Reset: a request during reset must not launch anything.
    step();
    reset     = 1'b1;
    txn_start = 1'b1;
    @(negedge clock);
    chk("rst_no_tx_start", int'(tx_start), 0);
    step();
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", int'(txn_ready), 1);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_send_ack", int'(send_ack), 0);
    chk("rst_rec_start", int'(rec_start), 0);
    chk("rst_txn_done", int'(txn_done), 0);
    chk("rst_success", int'(txn_success), 0);
    chk("rst_retries", int'(txn_retries), 0);
    step();

    // Table vectors, issued back to back.
    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].is_in, vecs[i].r0, vecs[i].r1, vecs[i].r2,
              vecs[i].succ, vecs[i].rtr, vecs[i].ntx, vecs[i].nack);

    // Busy requests ignored, then reset in RX_WAIT while a retry would fire.
    txn_start = 1'b1;
    txn_is_in = 1'b0;
    wait_evt(kind);
    chk("mid_start", kind, 1);
    step();
    tx_done = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      txn_start = 1'b1;
      @(negedge clock);
      chk("busy_ignore_tx", int'(tx_start), 0);
      chk("busy_not_ready", int'(txn_ready), 0);
    end
    step();
    txn_start  = 1'b1;
    rec_failed = 1'b1;
    reset      = 1'b1;
    @(negedge clock);
    chk("rst_cycle_tx_start", int'(tx_start), 0);
    chk("rst_cycle_rec_start", int'(rec_start), 0);
    chk("rst_cycle_done", int'(txn_done), 0);
    step();
    reset     = 1'b0;
    txn_start = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", int'(txn_ready), 1);
    chk("post_rst_accept", int'(tx_start), 1);
    chk("post_rst_retries", int'(txn_retries), 0);
    chk("post_rst_success", int'(txn_success), 0);
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    prev_succ = 1'b0;

    // Random transactions against the outcome model.
    for (int i = 0; i < 30; i++) begin
      in_r = 1'($urandom_range(0, 1));
      q0   = rand_resp();
      q1   = rand_resp();
      q2   = rand_resp();
      model(in_r, q0, q1, q2, s_m, rt_m, tx_m, ak_m);
      run_txn(in_r, q0, q1, q2, s_m, rt_m, tx_m, ak_m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_rx_txn_sequencer.md
Name: usb_rx_txn_sequencer

Overview:
Host-side transaction sequencer sitting above the packet encoder and the DP/DM receive decoder. It accepts one OUT or IN transaction request, starts transmission, arms the receiver, waits for the handshake or data response with a timeout, and waits for EOP. For IN it returns an ACK after good DATA0. It retries on NAK, receive failure, CRC error or timeout up to a limit, then reports a single done/success result to the protocol layer.

Parameters:
TIMEOUT_CYC, 256, cycles allowed in RX_WAIT or RX_EOP before declaring timeout (>=2)
MAX_RETRY, 8, retries allowed after first attempt before failing (>=0)
RW, 4, width of retry counter output (must hold MAX_RETRY)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
txn_start  in  1  request pulse; sampled only in IDLE
txn_is_in  in  1  1=IN (expect DATA0), 0=OUT (expect ACK/NAK); latched with txn_start
txn_ready  out  1  high only in IDLE
tx_start  out  1  1-cycle pulse: encoder sends token/data packet
send_ack  out  1  1-cycle pulse: encoder sends ACK handshake
tx_done  in  1  encoder finished current packet (pulse)
rec_start  out  1  1-cycle pulse arming the receive decoder
ACK_rec  in  1  decoder saw ACK PID (pulse)
NAK_rec  in  1  decoder saw NAK PID (pulse)
DATA0_rec  in  1  decoder saw DATA0 PID (pulse)
rec_failed  in  1  decoder PID/sync failure (pulse)
rec_eop  in  1  decoder completed EOP (pulse)
crc_ok  in  1  valid with rec_eop for DATA0 packets
txn_done  out  1  1-cycle completion pulse
txn_success  out  1  result, valid with txn_done, held until next txn_start
txn_retries  out  RW  retries used, valid with txn_done, held

Behaviour:
- Reset: state IDLE; tx_start, send_ack, rec_start, txn_done, txn_success = 0; txn_retries = 0; timer = 0; retry count = 0.
- States: IDLE, TX, RX_WAIT, RX_EOP, TX_ACK, DONE.
- IDLE: txn_ready=1. On txn_start: latch txn_is_in, clear retry count, txn_success=0, and assert tx_start in the same cycle. Then go to TX. A txn_start in any other state is ignored.
- TX: wait for tx_done. On tx_done: assert rec_start in the same cycle, clear the timer, and go to RX_WAIT.
- RX_WAIT: the timer increments each cycle. Outcome priority, highest first: rec_failed, then a PID event, then timeout.
  - rec_failed: retry.
  - OUT + ACK_rec: record good and go to RX_EOP.
  - OUT + NAK_rec or DATA0_rec: record bad and go to RX_EOP.
  - IN + DATA0_rec: record pending-CRC and go to RX_EOP.
  - IN + ACK_rec or NAK_rec: record bad and go to RX_EOP.
  - Timeout when timer == TIMEOUT_CYC-1 with no event: retry.
- Entering RX_EOP clears the timer. In RX_EOP, on rec_eop:
  - good: go to DONE with success=1.
  - pending-CRC with crc_ok=1: assert send_ack and go to TX_ACK.
  - pending-CRC with crc_ok=0, or bad: retry.
  - Timer reaching TIMEOUT_CYC-1 without rec_eop: retry.
- TX_ACK: on tx_done, go to DONE with success=1.
- Retry action:
  - If retry count == MAX_RETRY: go to DONE with success=0.
  - Otherwise: increment retry count, assert tx_start the same cycle, and go to TX.
- DONE: txn_done=1 for exactly one cycle. txn_success and txn_retries are updated. Next state is IDLE. Back-to-back: txn_start is accepted in the IDLE cycle immediately after DONE.
- Minimum OUT latency: txn_start to txn_done = 3 cycles plus encoder and decoder time.
- Unexpected tx_done, rec_eop or PID pulses in states not listed above are ignored.
- Reset asserted mid-transaction: next cycle is IDLE with all outputs at reset values. No pulse is emitted in the reset cycle.
- Timer width is clog2(TIMEOUT_CYC); it saturates and never wraps.

Decomposition:
- Shared usb_pkg holds the state enum type, the outcome enum {OC_GOOD, OC_BAD, OC_CRC}, and the PID constants already used by the decode FSM.
- One natural sub-module: usb_timeout_timer (clear, enable, expired; parameter TIMEOUT_CYC). It is reused by the transmit side.

Test Plan:
- OUT: txn_is_in=0, tx_done, ACK_rec, rec_eop -> one txn_done, txn_success=1, txn_retries=0; exactly one tx_start and one rec_start.
- OUT with NAK on the first 3 attempts, then ACK -> 4 tx_start pulses; txn_done with success=1, retries=3.
- IN: DATA0_rec, rec_eop with crc_ok=1 -> send_ack pulse; after tx_done, txn_success=1. Repeat with crc_ok=0 on the first attempt -> retries=1, no send_ack on the failed attempt.
- Silent receiver with MAX_RETRY=2, TIMEOUT_CYC=16 -> 3 tx_start pulses, each RX_WAIT lasts 16 cycles; txn_done with success=0, retries=2.
- rec_failed and ACK_rec in the same cycle -> treated as failure (retry); ACK_rec coinciding with the timeout cycle -> ACK wins.
- reset asserted in RX_WAIT, txn_start held during busy states -> IDLE next cycle with outputs 0; txn_start ignored while busy and accepted in IDLE.
